core_operand_loader: RTL

- Upstream feeder and result capture for the 60-input / 26-output combinational ALU-control benchmark core.
- Accepts the core's input vector as a narrow chunked valid/ready stream and assembles it in a register that drives the core directly.
- Waits a programmable settle interval, then registers the core's 26 outputs and presents them on a valid/ready result port.
- Lets the purely combinational core be exercised from a clocked test or system fabric.

---
 rtl/core_operand_loader_pkg.sv | 29 ++
 rtl/core_chunk_assembler.sv | 93 +++++++++
 rtl/core_operand_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/core_operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// core_operand_loader_pkg
// Shared constants and types for the operand loader that feeds the
// 60-input / 26-output combinational ALU-control benchmark core.
//   IN_W / OUT_W : core input / output vector widths
//   CHUNK_W      : width of one input stream chunk
//   NCHUNK       : chunks per input vector, ceil(IN_W / CHUNK_W)
//   state_e      : loader FSM states
// -----------------------------------------------------------------------------
package core_operand_loader_pkg;

  localparam int IN_W    = 60;
  localparam int OUT_W   = 26;
  localparam int CHUNK_W = 8;

  function automatic int calc_nchunk(input int in_w, input int chunk_w);
    return (in_w + chunk_w - 1) / chunk_w;
  endfunction

  localparam int NCHUNK = calc_nchunk(IN_W, CHUNK_W);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/core_chunk_assembler.sv
// -----------------------------------------------------------------------------
// core_chunk_assembler
// Collects CHUNK_W-wide stream chunks into the IN_W-bit core input register
// and checks that in_last marks exactly the final chunk of each vector.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clr        : synchronous flush (index -> 0, no write this cycle)
//   i_en         : loader is in its load phase (in_ready)
//   i_data       : chunk payload; bits beyond IN_W in the last chunk are dropped
//   i_valid      : chunk valid
//   i_last       : chunk is the last one of its vector
//   o_core_vec   : assembled vector, registered
//   o_vec_done   : final chunk accepted with in_last (one-cycle pulse)
//   o_frame_err  : sticky framing error, cleared only by reset
// -----------------------------------------------------------------------------
module core_chunk_assembler
  import core_operand_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [CHUNK_W-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_last,
  output logic [IN_W-1:0]    o_core_vec,
  output logic               o_vec_done,
  output logic               o_frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  logic [IDX_W-1:0] r_idx;
  logic [IN_W-1:0]  r_core_vec;
  logic             r_frame_err;
  logic [IN_W-1:0]  w_vec_next;
  logic             w_accept;
  logic             w_is_final;

  // A flush in the same cycle discards the chunk.
  assign w_accept   = i_valid & i_en & ~i_clr;
  assign w_is_final = (r_idx == LAST_IDX);

  // Merge the accepted chunk into its slot; bit b belongs to chunk b/CHUNK_W.
  always_comb begin
    w_vec_next = r_core_vec;
    for (int b = 0; b < IN_W; b++) begin
      if (w_accept && (r_idx == IDX_W'(b / CHUNK_W))) begin
        w_vec_next[b] = i_data[b % CHUNK_W];
      end else begin
        w_vec_next[b] = r_core_vec[b];
      end
    end
  end

  // Core input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_vec <= '0;
    end else begin
      r_core_vec <= w_vec_next;
    end
  end

  // Chunk index and framing check; any framing problem restarts at chunk 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_frame_err <= 1'b0;
    end else if (i_clr) begin
      r_idx       <= '0;
      r_frame_err <= r_frame_err;
    end else if (w_accept) begin
      if (w_is_final) begin
        r_idx       <= '0;
        r_frame_err <= r_frame_err | ~i_last;
      end else if (i_last) begin
        r_idx       <= '0;
        r_frame_err <= 1'b1;
      end else begin
        r_idx       <= r_idx + IDX_W'(1);
        r_frame_err <= r_frame_err;
      end
    end else begin
      r_idx       <= r_idx;
      r_frame_err <= r_frame_err;
    end
  end

  assign o_core_vec  = r_core_vec;
  assign o_vec_done  = w_accept & w_is_final & i_last;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/core_operand_loader.sv
// -----------------------------------------------------------------------------
// core_operand_loader
// Feeds the combinational benchmark core from a chunked valid/ready stream,
// waits SETTLE_CYC extra cycles for the core to propagate, then captures the
// core outputs and offers them on a valid/ready result port.
//   clk, rst_n       : clock, asynchronous active-low reset
//   clr              : synchronous flush to LOAD (keeps core_vec/frame_err/txn_cnt)
//   in_data/in_last/in_valid/in_ready : chunk stream
//   core_vec/core_vec_valid           : registered drive to the core inputs
//   core_res                          : combinational core outputs
//   res_data/res_valid/res_ready      : captured result stream
//   frame_err        : sticky framing error
//   txn_cnt          : completed result handshakes, wraps
// -----------------------------------------------------------------------------
module core_operand_loader
  import core_operand_loader_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [IN_W-1:0]    core_vec,
  output logic               core_vec_valid,
  input  logic [OUT_W-1:0]   core_res,
  output logic [OUT_W-1:0]   res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               frame_err,
  output logic [15:0]        txn_cnt
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_e            r_state;
  state_e            w_state_next;
  logic [3:0]        r_settle;
  logic [OUT_W-1:0]  r_res_data;
  logic [15:0]       r_txn_cnt;
  logic              w_in_ready;
  logic              w_vec_valid;
  logic              w_res_valid;
  logic              w_vec_done;
  logic              w_capture;
  logic              w_res_hs;
  logic [IN_W-1:0]   w_core_vec;
  logic              w_frame_err;

  core_chunk_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (clr),
    .i_en        (w_in_ready),
    .i_data      (in_data),
    .i_valid     (in_valid),
    .i_last      (in_last),
    .o_core_vec  (w_core_vec),
    .o_vec_done  (w_vec_done),
    .o_frame_err (w_frame_err)
  );

  // Capture happens on the edge where the settle count has run out.
  assign w_capture = (r_state == ST_SETTLE) & (r_settle == 4'd0) & ~clr;
  assign w_res_hs  = (r_state == ST_HOLD) & res_ready & ~clr;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; clr overrides every other event.
  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:   w_state_next = w_vec_done ? ST_SETTLE : ST_LOAD;
        ST_SETTLE: w_state_next = (r_settle == 4'd0) ? ST_HOLD : ST_SETTLE;
        ST_HOLD:   w_state_next = res_ready ? ST_LOAD : ST_HOLD;
        default:   w_state_next = ST_LOAD;
      endcase
    end
  end

  // FSM output decode.
  always_comb begin
    w_in_ready  = 1'b0;
    w_vec_valid = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_in_ready = 1'b1;
      end
      ST_SETTLE: begin
        w_vec_valid = 1'b1;
      end
      ST_HOLD: begin
        w_vec_valid = 1'b1;
        w_res_valid = 1'b1;
      end
      default: begin
        w_in_ready = 1'b1;
      end
    endcase
  end

  // Settle counter: loaded on the final-chunk handshake, counts down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= 4'd0;
    end else if (w_vec_done) begin
      r_settle <= SETTLE_LD;
    end else if ((r_state == ST_SETTLE) && (r_settle != 4'd0) && !clr) begin
      r_settle <= r_settle - 4'd1;
    end else begin
      r_settle <= r_settle;
    end
  end

  // Result register and transaction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data <= '0;
      r_txn_cnt  <= 16'd0;
    end else begin
      if (w_capture) begin
        r_res_data <= core_res;
      end else begin
        r_res_data <= r_res_data;
      end
      if (w_res_hs) begin
        r_txn_cnt <= r_txn_cnt + 16'd1;
      end else begin
        r_txn_cnt <= r_txn_cnt;
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign core_vec       = w_core_vec;
  assign core_vec_valid = w_vec_valid;
  assign res_data       = r_res_data;
  assign res_valid      = w_res_valid;
  assign frame_err      = w_frame_err;
  assign txn_cnt        = r_txn_cnt;

endmodule
